// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   - ctrl_state_e : sequencer FSM states (RUN, MD_WAIT)
//   - default values for the MD_TIMEOUT and STALL_CNT_W parameters
//   - decode_e     : hazard resolutions; the encoded value is the priority
//                    rank in RUN (lower value wins)
//   - strobes_t    : per-stage enable/flush bundle, plus decode_strobes()
//                    which maps a resolution onto that bundle
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } ctrl_state_e;

    localparam int MD_TIMEOUT_DEF  = 40;
    localparam int STALL_CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        DEC_MD_DONE  = 3'd0,
        DEC_MD_STALL = 3'd1,
        DEC_BRANCH   = 3'd2,
        DEC_LOAD_USE = 3'd3,
        DEC_NORMAL   = 3'd4
    } decode_e;

    typedef struct packed {
        logic pc_en;
        logic fd_en;
        logic dx_en;
        logic xm_en;
        logic mw_en;
        logic fd_flush;
        logic dx_flush;
        logic mw_flush;
    } strobes_t;

    function automatic strobes_t decode_strobes(input decode_e dec);
        strobes_t s;
        s = '{pc_en: 1'b1, fd_en: 1'b1, dx_en: 1'b1, xm_en: 1'b1,
              mw_en: 1'b1, fd_flush: 1'b0, dx_flush: 1'b0, mw_flush: 1'b0};
        case (dec)
            DEC_MD_STALL: begin
                // Front end and XM hold the mult/div in place; MW drains a bubble.
                s.pc_en    = 1'b0;
                s.fd_en    = 1'b0;
                s.dx_en    = 1'b0;
                s.xm_en    = 1'b0;
                s.mw_flush = 1'b1;
            end
            DEC_BRANCH: begin
                s.fd_flush = 1'b1;
                s.dx_flush = 1'b1;
            end
            DEC_LOAD_USE: begin
                // Hold PC/FD for one cycle and let a nop enter DX.
                s.pc_en    = 1'b0;
                s.fd_en    = 1'b0;
                s.dx_flush = 1'b1;
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset (count -> 0)
//   clr_i   - synchronous clear, dominates inc_i
//   inc_i   - add one at the next edge unless saturated
//   count_o - current count
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the five-stage pipeline.
// Decodes load-use hazards, taken branches and multi-cycle mult/div into
// per-stage load enables and flush strobes, and counts front-end stall cycles.
// Ports:
//   clk, reset (async, active-low)
//   load_use_hazard, branch_taken, md_start, md_ready, ra_write_req - requests
//   pc/fd/dx/xm/mw_enable, mw_ra_enable                             - load enables
//   fd_flush, dx_flush, mw_flush                                    - nop inserts
//   md_timeout  - sticky mult/div timeout flag
//   stall_count - saturating count of cycles with pc_enable = 0
// Build option: define PIPELINE_CTRL_MD_TIMEOUT_EN to force release from
// MD_WAIT after MD_TIMEOUT wait cycles without md_ready.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT  = MD_TIMEOUT_DEF,
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_use_hazard,
    input  logic                   branch_taken,
    input  logic                   md_start,
    input  logic                   md_ready,
    input  logic                   ra_write_req,
    output logic                   pc_enable,
    output logic                   fd_enable,
    output logic                   dx_enable,
    output logic                   xm_enable,
    output logic                   mw_enable,
    output logic                   mw_ra_enable,
    output logic                   fd_flush,
    output logic                   dx_flush,
    output logic                   mw_flush,
    output logic                   md_timeout,
    output logic [STALL_CNT_W-1:0] stall_count
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;
    decode_e     dec;
    strobes_t    strb;
    logic        md_release;

`ifdef PIPELINE_CTRL_MD_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MD_TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;
    logic              md_timeout_q;
    logic              md_timeout_d;

    // Held at zero throughout RUN, so it always starts from zero on entry.
    sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .clr_i   (state_q == RUN),
        .inc_i   (state_q == MD_WAIT),
        .count_o (wait_cnt)
    );

    // wait_cnt equals the number of wait cycles already completed.
    assign timeout_hit  = (state_q == MD_WAIT) && !md_ready
                          && (wait_cnt == WAIT_W'(MD_TIMEOUT));
    assign md_timeout_d = md_timeout_q | timeout_hit;
    assign md_release   = md_ready | timeout_hit;
    assign md_timeout   = md_timeout_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_timeout_q <= 1'b0;
        end else begin
            md_timeout_q <= md_timeout_d;
        end
    end
`else
    logic unused_md_timeout_param;

    assign unused_md_timeout_param = ^MD_TIMEOUT;
    assign md_release              = md_ready;
    assign md_timeout              = 1'b0;
`endif

    // Resolution select: MD_WAIT only watches for completion; RUN walks the
    // hazards in priority order.
    always_comb begin
        state_d = state_q;
        dec     = DEC_NORMAL;
        if (state_q == MD_WAIT) begin
            if (md_release) begin
                dec     = DEC_MD_DONE;
                state_d = RUN;
            end else begin
                dec = DEC_MD_STALL;
            end
        end else begin
            if (md_start && md_ready) begin
                dec = DEC_MD_DONE;
            end else if (md_start) begin
                dec     = DEC_MD_STALL;
                state_d = MD_WAIT;
            end else if (branch_taken) begin
                dec = DEC_BRANCH;
            end else if (load_use_hazard) begin
                dec = DEC_LOAD_USE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Every strobe is forced low while reset is asserted.
    assign strb = reset ? decode_strobes(dec) : '0;

    assign pc_enable    = strb.pc_en;
    assign fd_enable    = strb.fd_en;
    assign dx_enable    = strb.dx_en;
    assign xm_enable    = strb.xm_en;
    assign mw_enable    = strb.mw_en;
    assign fd_flush     = strb.fd_flush;
    assign dx_flush     = strb.dx_flush;
    assign mw_flush     = strb.mw_flush;
    assign mw_ra_enable = strb.mw_en & ra_write_req & ~strb.mw_flush;

    sat_counter #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .clr_i   (1'b0),
        .inc_i   (!pc_enable),
        .count_o (stall_count)
    );

endmodule
